// File: rtl/psum_collector_pkg.sv
// Shared packet definitions for the PE output network.
// Holds the packet-type codes, fixed header field positions and the default
// data/packet widths used by the PE packetizer, depacketizer and collector.
package psum_collector_pkg;

  localparam int unsigned DefDwidth = 8;
  localparam int unsigned DefPwidth = 47;

  // Fixed header fields at the top of every packet.
  localparam int unsigned TypeHi = 46;
  localparam int unsigned TypeLo = 45;
  localparam int unsigned PeHi   = 44;
  localparam int unsigned PeLo   = 42;

  typedef enum logic [1:0] {
    PktFilter = 2'b00,
    PktPixel  = 2'b01,
    PktPsum   = 2'b10,
    PktRsvd   = 2'b11
  } pkt_type_e;

  // The 2-bit column field sits directly above the psum value.
  function automatic int unsigned col_lo(input int unsigned dwidth);
    return dwidth;
  endfunction

endpackage

// File: rtl/psum_slot.sv
// One column slot of the partial-sum collector.
// Accumulates contributions from up to NUM_PE PEs and tracks which PEs have
// already contributed.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   i_add            add i_value and set the bits of i_pe_oh
//   i_pe_oh          one-hot contributing PE
//   i_value          unsigned partial-sum value
//   i_clear          clear sum and mask (slot emitted); wins over i_add
//   o_sum            running sum, DWIDTH+2 bits
//   o_mask           received mask
//   o_full           every PE has contributed
module psum_slot
  import psum_collector_pkg::*;
#(
  parameter int unsigned DWIDTH = DefDwidth,
  parameter int unsigned NUM_PE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_add,
  input  logic [NUM_PE-1:0] i_pe_oh,
  input  logic [DWIDTH-1:0] i_value,
  input  logic              i_clear,
  output logic [DWIDTH+1:0] o_sum,
  output logic [NUM_PE-1:0] o_mask,
  output logic              o_full
);

  logic [DWIDTH+1:0] r_sum;
  logic [NUM_PE-1:0] r_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum  <= '0;
      r_mask <= '0;
    end else if (i_clear) begin
      r_sum  <= '0;
      r_mask <= '0;
    end else if (i_add) begin
      r_sum  <= r_sum + {2'b00, i_value};
      r_mask <= r_mask | i_pe_oh;
    end
  end

  assign o_sum  = r_sum;
  assign o_mask = r_mask;
  assign o_full = &r_mask;

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector: sums NUM_PE contributions per output column and
// emits completed columns strictly in column order.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   in_data      network packet (type, PE index, column, psum value)
//   in_valid     in_data valid
//   in_ready     packet accepted this cycle
//   out_data     summed pixel, DWIDTH+2 bits
//   out_col      column index of out_data
//   out_valid    out_data/out_col valid
//   out_ready    downstream accepts the output
//   err_dup      pulse: duplicate PE contribution dropped
//   err_type     pulse: non-psum or out-of-range packet dropped
//   frame_done   pulse: last column of the row emitted
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int unsigned DWIDTH  = DefDwidth,
  parameter int unsigned PWIDTH  = DefPwidth,
  parameter int unsigned NUM_PE  = 3,
  parameter int unsigned NUM_COL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH+1:0] out_data,
  output logic [1:0]        out_col,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_dup,
  output logic              err_type,
  output logic              frame_done
);

  localparam int unsigned ColLo   = col_lo(DWIDTH);
  localparam logic [1:0]  LastCol = 2'(NUM_COL - 1);

  // Packet fields
  pkt_type_e         w_type;
  logic [2:0]        w_pe;
  logic [1:0]        w_col;
  logic [DWIDTH-1:0] w_value;
  logic              w_unused_bits;

  assign w_type        = pkt_type_e'(in_data[TypeHi:TypeLo]);
  assign w_pe          = in_data[PeHi:PeLo];
  assign w_col         = in_data[ColLo+1:ColLo];
  assign w_value       = in_data[DWIDTH-1:0];
  assign w_unused_bits = ^in_data[PeLo-1:ColLo+2];

  // Slot interface
  logic [DWIDTH+1:0]  w_sum  [NUM_COL];
  logic [NUM_PE-1:0]  w_mask [NUM_COL];
  logic [NUM_COL-1:0] w_full;
  logic [NUM_COL-1:0] w_add;
  logic [NUM_COL-1:0] w_clear;

  logic [NUM_PE-1:0]  w_pe_oh;
  logic [NUM_PE-1:0]  w_sel_mask;
  logic               w_sel_full;
  logic [DWIDTH+1:0]  w_out_sum;
  logic               w_out_full;

  logic w_pe_ok;
  logic w_col_ok;
  logic w_good;
  logic w_accept;
  logic w_dup;
  logic w_add_any;
  logic w_emit;

  logic [1:0] r_ptr;
  logic       r_err_dup;
  logic       r_err_type;
  logic       r_frame_done;

  assign w_pe_ok  = 32'(w_pe) < NUM_PE;
  assign w_col_ok = 32'(w_col) < NUM_COL;
  assign w_good   = (w_type == PktPsum) && w_pe_ok && w_col_ok;

  always_comb begin
    w_pe_oh    = '0;
    w_sel_mask = '0;
    w_sel_full = 1'b0;
    w_out_sum  = '0;
    w_out_full = 1'b0;
    for (int p = 0; p < NUM_PE; p++) begin
      if (w_pe == 3'(p)) w_pe_oh[p] = 1'b1;
    end
    for (int k = 0; k < NUM_COL; k++) begin
      if (w_col == 2'(k)) begin
        w_sel_mask = w_mask[k];
        w_sel_full = w_full[k];
      end
      if (r_ptr == 2'(k)) begin
        w_out_sum  = w_sum[k];
        w_out_full = w_full[k];
      end
    end
  end

  // A full slot is by construction not yet emitted (emitting clears it), so
  // stalling on a full addressed column is exactly the back-pressure rule.
  assign in_ready  = !(w_col_ok && w_sel_full);
  assign w_accept  = in_valid && in_ready;
  assign w_dup     = w_good && |(w_sel_mask & w_pe_oh);
  assign w_add_any = w_accept && w_good && !w_dup;

  assign out_valid = w_out_full;
  assign out_data  = w_out_sum;
  assign out_col   = r_ptr;
  assign w_emit    = out_valid && out_ready;

  for (genvar k = 0; k < NUM_COL; k++) begin : g_slot
    assign w_add[k]   = w_add_any && (w_col == 2'(k));
    assign w_clear[k] = w_emit && (r_ptr == 2'(k));

    psum_slot #(
      .DWIDTH (DWIDTH),
      .NUM_PE (NUM_PE)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .i_add   (w_add[k]),
      .i_pe_oh (w_pe_oh),
      .i_value (w_value),
      .i_clear (w_clear[k]),
      .o_sum   (w_sum[k]),
      .o_mask  (w_mask[k]),
      .o_full  (w_full[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_err_dup    <= 1'b0;
      r_err_type   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_err_dup    <= w_accept && w_dup;
      r_err_type   <= w_accept && !w_good;
      r_frame_done <= w_emit && (r_ptr == LastCol);
      if (w_emit) begin
        r_ptr <= (r_ptr == LastCol) ? 2'd0 : r_ptr + 2'd1;
      end
    end
  end

  assign err_dup    = r_err_dup;
  assign err_type   = r_err_type;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_psum_collector.sv
// Bench for psum_collector: directed scenarios plus randomized traffic checked
// against a per-column, per-PE contribution table.
module tb_psum_collector;

  localparam int DW   = 8;
  localparam int PW   = 47;
  localparam int NPE  = 3;
  localparam int NCOL = 3;
  localparam bit [1:0] PSUM = 2'b10;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW+1:0] out_data;
  logic [1:0]    out_col;
  logic          out_valid;
  logic          out_ready;
  logic          err_dup;
  logic          err_type;
  logic          frame_done;

  always #5 clk = ~clk;

  psum_collector #(
    .DWIDTH  (DW),
    .PWIDTH  (PW),
    .NUM_PE  (NPE),
    .NUM_COL (NCOL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_dup    (err_dup),
    .err_type   (err_type),
    .frame_done (frame_done)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference: which PE has contributed what to each column, plus the pointer.
  bit m_got [NCOL][NPE];
  int m_val [NCOL][NPE];
  int m_ptr;

  // Expected values (from the model) and observed values for the last drive.
  bit        e_ready, e_valid, e_dup, e_type, e_frame;
  bit [9:0]  e_data;
  bit [1:0]  e_col;
  logic      o_ready, o_valid, o_dup, o_type, o_frame;
  logic [9:0] o_data;
  logic [1:0] o_col;

  function automatic bit m_full(input int c);
    for (int p = 0; p < NPE; p++) if (!m_got[c][p]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_sum(input int c);
    int s = 0;
    for (int p = 0; p < NPE; p++) if (m_got[c][p]) s += m_val[c][p];
    return s;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NCOL; c++)
      for (int p = 0; p < NPE; p++) begin
        m_got[c][p] = 1'b0;
        m_val[c][p] = 0;
      end
    m_ptr = 0;
  endfunction

  function automatic logic [PW-1:0] mk_pkt(input bit [1:0] t, input bit [2:0] pe,
                                           input bit [1:0] col, input bit [7:0] val);
    logic [PW-1:0] p;
    p        = '0;
    p[41:10] = $urandom();  // don't-care bits between header and column
    p[46:45] = t;
    p[44:42] = pe;
    p[9:8]   = col;
    p[7:0]   = val;
    return p;
  endfunction

  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic drive(input bit v, input bit [1:0] t, input bit [2:0] pe, input bit [1:0] col,
                       input bit [7:0] val, input bit ordy);
    bit acc, emit, bad;
    in_valid  = v;
    in_data   = mk_pkt(t, pe, col, val);
    out_ready = ordy;
    #1;
    e_ready = !(col < NCOL && m_full(col));
    e_valid = m_full(m_ptr);
    e_data  = 10'(m_sum(m_ptr));
    e_col   = 2'(m_ptr);
    o_ready = in_ready;
    o_valid = out_valid;
    o_data  = out_data;
    o_col   = out_col;
    acc  = v && e_ready;
    emit = e_valid && ordy;
    bad  = (t != PSUM) || (pe >= NPE) || (col >= NCOL);
    @(posedge clk);
    e_dup   = 1'b0;
    e_type  = 1'b0;
    e_frame = 1'b0;
    if (emit) begin
      for (int p = 0; p < NPE; p++) m_got[m_ptr][p] = 1'b0;
      e_frame = (m_ptr == NCOL - 1);
      m_ptr   = (m_ptr + 1) % NCOL;
    end
    if (acc) begin
      if (bad) e_type = 1'b1;
      else if (m_got[col][pe]) e_dup = 1'b1;
      else begin
        m_got[col][pe] = 1'b1;
        m_val[col][pe] = int'(val);
      end
    end
    @(negedge clk);
    o_dup   = err_dup;
    o_type  = err_type;
    o_frame = frame_done;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, PSUM, 3'd0, 2'd0, 8'd0, ordy);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    drive(1'b1, PSUM, 3'd0, 2'd0, 8'h55, 1'b0);
    drive(1'b1, PSUM, 3'd1, 2'd0, 8'h11, 1'b0);
    drive(1'b1, PSUM, 3'd2, 2'd0, 8'h22, 1'b0);
    drive(1'b1, 2'b01, 3'd0, 2'd1, 8'h03, 1'b0);
    n_total++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got=%b want=1", out_valid); end
    n_total++;
    if (err_type !== 1'b1) begin n_bad++; $display("FAIL pre_reset_errtype got=%b want=1", err_type); end
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = mk_pkt(PSUM, 3'd0, 2'd0, 8'd0);
    #1;
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    n_total++;
    if (out_data !== 10'd0) begin n_bad++; $display("FAIL rst_out_data got=%0d want=0", out_data); end
    n_total++;
    if (out_col !== 2'd0) begin n_bad++; $display("FAIL rst_out_col got=%0d want=0", out_col); end
    n_total++;
    if (err_dup !== 1'b0) begin n_bad++; $display("FAIL rst_err_dup got=%b want=0", err_dup); end
    n_total++;
    if (err_type !== 1'b0) begin n_bad++; $display("FAIL rst_err_type got=%b want=0", err_type); end
    n_total++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done got=%b want=0", frame_done); end
    n_total++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_column();
    do_reset();
    drive(1'b1, PSUM, 3'd0, 2'd0, 8'd10, 1'b1);
    drive(1'b1, PSUM, 3'd1, 2'd0, 8'd20, 1'b1);
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid got=%b want=0", out_valid); end
    drive(1'b1, PSUM, 3'd2, 2'd0, 8'd30, 1'b1);
    n_total++;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL c0_valid got=%b want=1", out_valid); end
    n_total++;
    if (out_data !== 10'd60) begin n_bad++; $display("FAIL c0_data got=%0d want=60", out_data); end
    n_total++;
    if (out_col !== 2'd0) begin n_bad++; $display("FAIL c0_col got=%0d want=0", out_col); end
    idle(1'b1);
    n_total++;
    if (out_valid !== 1'b0 || out_col !== 2'd1) begin
      n_bad++; $display("FAIL c0_after got=%b/%0d want=0/1", out_valid, out_col);
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int p = 0; p < NPE; p++) drive(1'b1, PSUM, 3'(p), 2'd1, 8'd255, 1'b1);
    idle(1'b1);
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_hold got=%b want=0", out_valid); end
    drive(1'b1, PSUM, 3'd2, 2'd0, 8'd1, 1'b1);
    drive(1'b1, PSUM, 3'd0, 2'd0, 8'd2, 1'b1);
    drive(1'b1, PSUM, 3'd1, 2'd0, 8'd3, 1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_col !== 2'd0 || out_data !== 10'd6) begin
      n_bad++; $display("FAIL ooo_c0 got=%b/%0d/%0d want=1/0/6", out_valid, out_col, out_data);
    end
    idle(1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_col !== 2'd1 || out_data !== 10'd765) begin
      n_bad++; $display("FAIL ooo_c1 got=%b/%0d/%0d want=1/1/765", out_valid, out_col, out_data);
    end
    idle(1'b1);
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ooo_end got=%b want=0", out_valid); end
  endtask

  task automatic test_duplicate();
    int pulses = 0;
    do_reset();
    drive(1'b1, PSUM, 3'd1, 2'd2, 8'd5, 1'b0);
    pulses += int'(err_dup);
    drive(1'b1, PSUM, 3'd1, 2'd2, 8'd9, 1'b0);
    pulses += int'(err_dup);
    n_total++;
    if (err_dup !== 1'b1) begin n_bad++; $display("FAIL dup_pulse got=%b want=1", err_dup); end
    drive(1'b1, PSUM, 3'd0, 2'd2, 8'd7, 1'b0);
    pulses += int'(err_dup);
    drive(1'b1, PSUM, 3'd2, 2'd2, 8'd8, 1'b0);
    pulses += int'(err_dup);
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < NPE; p++) begin
        drive(1'b1, PSUM, 3'(p), 2'(c), 8'd0, 1'b0);
        pulses += int'(err_dup);
      end
    n_total++;
    if (pulses != 1) begin n_bad++; $display("FAIL dup_count got=%0d want=1", pulses); end
    idle(1'b1);
    idle(1'b1);
    n_total++;
    if (out_valid !== 1'b1 || out_col !== 2'd2 || out_data !== 10'd20) begin
      n_bad++; $display("FAIL dup_sum got=%b/%0d/%0d want=1/2/20", out_valid, out_col, out_data);
    end
  endtask

  task automatic test_bad_type();
    do_reset();
    drive(1'b1, PSUM, 3'd0, 2'd0, 8'd7, 1'b0);
    drive(1'b1, 2'b01, 3'd1, 2'd0, 8'd99, 1'b0);
    n_total++;
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL type_ready got=%b want=1", o_ready); end
    n_total++;
    if (err_type !== 1'b1) begin n_bad++; $display("FAIL type_pulse got=%b want=1", err_type); end
    drive(1'b1, PSUM, 3'd5, 2'd0, 8'd50, 1'b0);
    n_total++;
    if (err_type !== 1'b1) begin n_bad++; $display("FAIL pe_range got=%b want=1", err_type); end
    drive(1'b1, PSUM, 3'd1, 2'd3, 8'd50, 1'b0);
    n_total++;
    if (err_type !== 1'b1 || err_dup !== 1'b0) begin
      n_bad++; $display("FAIL col_range got=%b/%b want=1/0", err_type, err_dup);
    end
    drive(1'b1, PSUM, 3'd1, 2'd0, 8'd1, 1'b0);
    n_total++;
    if (err_type !== 1'b0) begin n_bad++; $display("FAIL type_clear got=%b want=0", err_type); end
    drive(1'b1, PSUM, 3'd2, 2'd0, 8'd2, 1'b0);
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 10'd10) begin
      n_bad++; $display("FAIL type_unchanged got=%b/%0d want=1/10", out_valid, out_data);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int p = 0; p < NPE; p++) drive(1'b1, PSUM, 3'(p), 2'd0, 8'(4 + p), 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PSUM, 3'd0, 2'd0, 8'd9, 1'b0);
      n_total++;
      if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== 10'd15 || o_col !== 2'd0) begin
        n_bad++;
        $display("FAIL stall got=%b/%b/%0d/%0d want=0/1/15/0", o_ready, o_valid, o_data, o_col);
      end
    end
    drive(1'b1, PSUM, 3'd0, 2'd0, 8'd9, 1'b1);
    n_total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_xfer got=%b/%b want=0/1", o_ready, o_valid);
    end
    idle(1'b1);
    n_total++;
    if (o_valid !== 1'b0 || o_col !== 2'd1) begin
      n_bad++; $display("FAIL stall_once got=%b/%0d want=0/1", o_valid, o_col);
    end
  endtask

  task automatic test_reset_mid_frame();
    int vals [NCOL][NPE];
    int s;
    do_reset();
    drive(1'b1, PSUM, 3'd0, 2'd0, 8'd100, 1'b1);
    drive(1'b1, PSUM, 3'd1, 2'd0, 8'd100, 1'b1);
    reset    = 1'b1;
    in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle(1'b1);
    n_total++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_quiet got=%b want=0", out_valid); end
    for (int c = 0; c < NCOL; c++) begin
      s = 0;
      for (int p = 0; p < NPE; p++) begin
        vals[c][p] = int'($urandom_range(0, 255));
        s += vals[c][p];
        drive(1'b1, PSUM, 3'(p), 2'(c), 8'(vals[c][p]), 1'b0);
      end
      n_total++;
      if (out_valid !== 1'b1 || out_col !== 2'(c) || out_data !== 10'(s)) begin
        n_bad++;
        $display("FAIL mid_col%0d got=%b/%0d/%0d want=1/%0d/%0d", c, out_valid, out_col, out_data,
                 c, s);
      end
      idle(1'b1);
      n_total++;
      if (frame_done !== (c == NCOL - 1)) begin
        n_bad++; $display("FAIL mid_frame%0d got=%b want=%b", c, frame_done, c == NCOL - 1);
      end
    end
  endtask

  task automatic test_random();
    bit [1:0] t;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : PSUM;
      drive(1'($urandom_range(0, 3) != 0), t, 3'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom()), 1'($urandom_range(0, 9) < 7));
      n_total++;
      if (o_ready !== e_ready || o_valid !== e_valid) begin
        n_bad++;
        $display("FAIL rnd_hs i=%0d got=%b/%b want=%b/%b", i, o_ready, o_valid, e_ready, e_valid);
      end
      if (e_valid) begin
        n_total++;
        if (o_data !== e_data || o_col !== e_col) begin
          n_bad++;
          $display("FAIL rnd_out i=%0d got=%0d/%0d want=%0d/%0d", i, o_data, o_col, e_data, e_col);
        end
      end
      n_total++;
      if (o_dup !== e_dup || o_type !== e_type || o_frame !== e_frame) begin
        n_bad++;
        $display("FAIL rnd_pulse i=%0d got=%b%b%b want=%b%b%b", i, o_dup, o_type, o_frame,
                 e_dup, e_type, e_frame);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_single_column();
    test_out_of_order();
    test_duplicate();
    test_bad_type();
    test_stall();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter DWIDTH, default 8: width of one partial-sum value.
REQ-002 Parameter PWIDTH, default 47: width of one network packet.
REQ-003 Parameter NUM_PE, default 3: number of PEs contributing to each output pixel.
REQ-004 Parameter NUM_COL, default 3: output pixels per frame row.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port in_data, input, PWIDTH: packet from the PE output network.
REQ-008 Port in_valid, input, 1: in_data is valid.
REQ-009 Port in_ready, output, 1: collector accepts in_data this cycle.
REQ-010 Port out_data, output, DWIDTH+2: summed output pixel.
REQ-011 Port out_col, output, 2: column index of out_data.
REQ-012 Port out_valid, output, 1: out_data and out_col are valid.
REQ-013 Port out_ready, input, 1: downstream accepts the output.
REQ-014 Port err_dup, output, 1: one-cycle pulse when a duplicate contribution is dropped.
REQ-015 Port err_type, output, 1: one-cycle pulse when a non-PSUM packet is dropped.
REQ-016 Port frame_done, output, 1: one-cycle pulse when column NUM_COL-1 is emitted.

Function
REQ-017 Packet fields: [46:45] type (00 filter, 01 pixel, 10 psum, 11 reserved); [44:42] source PE index; [DWIDTH+1:DWIDTH] column index; [DWIDTH-1:0] psum value, unsigned.
REQ-018 A transfer occurs on any rising edge with in_valid && in_ready, or out_valid && out_ready.
REQ-019 Each column has a slot holding a sum of width DWIDTH+2 and an NUM_PE-bit received mask.
REQ-020 An accepted psum packet with type 10, PE index < NUM_PE, column < NUM_COL and mask bit clear adds the value to the slot sum and sets the mask bit.
REQ-021 An accepted packet with type other than 10, PE index >= NUM_PE, or column >= NUM_COL is dropped, and err_type pulses the following cycle.
REQ-022 An accepted psum packet whose mask bit is already set is dropped, and err_dup pulses the following cycle.
REQ-023 in_ready deasserts only when the addressed column's mask is full and that column is not yet emitted; otherwise it is 1.
REQ-024 Output is strictly in column order: an emit pointer starts at 0, and out_valid asserts the cycle after the pointed slot's mask becomes full.
REQ-025 out_data and out_col hold stable while out_valid && !out_ready.
REQ-026 On output transfer: the slot's sum and mask clear and the pointer increments. When the pointer wraps from NUM_COL-1 to 0, frame_done pulses in the next cycle.
REQ-027 Simultaneous accept into slot k and emit from slot j != k: both take effect. Accept into the emitting slot cannot occur, by REQ-023.
REQ-028 Column slots fill out of order; the latency from the completing packet to out_valid is exactly 1 cycle when the pointer already targets that column.
REQ-029 The sum cannot overflow: NUM_PE*(2^DWIDTH-1) fits in DWIDTH+2 bits for NUM_PE <= 4.

Reset
REQ-030 While reset is high, the following values apply: all sums and masks 0, pointer 0, out_valid 0, out_data 0, out_col 0, err_dup 0, err_type 0, frame_done 0, in_ready 1.
REQ-031 Reset asserted mid-frame discards all partial contributions, and no output follows until new packets arrive.

Structure
REQ-032 Packet-type codes, field bit positions, and DWIDTH/PWIDTH defaults belong in the shared package used by the PE packetizer and depacketizer.
REQ-033 One sub-module, psum_slot, implements a single column's sum register and mask; it is instantiated NUM_COL times.

Verification
REQ-034 Scenario: PE0/1/2 send col0 values 10, 20, 30 with out_ready=1. Required response: out_data=60 and out_col=0 one cycle after the third packet.
REQ-035 Scenario: col1 completes (PE values 255, 255, 255) before col0. Required response: no output until col0 completes, then col0, then col1=765.
REQ-036 Scenario: PE1 sends col2 twice (values 5, then 9). Required response: err_dup pulses once, and the col2 sum includes only 5.
REQ-037 Scenario: a type-01 packet is presented. Required response: accepted, err_type pulses, and all slots are unchanged.
REQ-038 Scenario: out_ready held 0 with col0 complete, and a 4th col0 packet is presented. Required response: in_ready=0 and the output stays stable. Then out_ready=1 gives one transfer.
REQ-039 Scenario: reset is asserted after 2 of 3 col0 packets, then a full frame is sent. Required response: outputs reflect only the post-reset values, and frame_done pulses after col2.
